// File: rtl/arp_tx_gate_ctrl.sv
// Gates the user TX stream into the UDP TX path until the destination IP has
// a resolved MAC; drives ARP cache lookups, ARP request retries and drops.
module arp_tx_gate_ctrl #(
  parameter logic [31:0] P_DST_IP_ADDR      = {8'd192, 8'd168, 8'd100, 8'd100},
  parameter int unsigned P_SEEK_WAIT        = 16,
  parameter int unsigned P_ARP_RETRY_CYCLES = 156250,
  parameter int unsigned P_ARP_MAX_TRIES    = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_dst_ip,
  input  logic        i_dst_ip_valid,
  output logic [31:0] o_seek_ip,
  output logic        o_seek_valid,
  input  logic [47:0] i_seek_mac,
  input  logic        i_seek_mac_valid,
  output logic        o_arp_active,
  output logic [31:0] o_arp_active_dst_ip,
  output logic [47:0] o_dst_mac,
  output logic        o_dst_mac_valid,
  input  logic [63:0] s_axis_user_data,
  input  logic [31:0] s_axis_user_user,
  input  logic [7:0]  s_axis_user_keep,
  input  logic        s_axis_user_last,
  input  logic        s_axis_user_valid,
  output logic        s_axis_user_ready,
  output logic [63:0] m_axis_udp_data,
  output logic [31:0] m_axis_udp_user,
  output logic [7:0]  m_axis_udp_keep,
  output logic        m_axis_udp_last,
  output logic        m_axis_udp_valid,
  input  logic        m_axis_udp_ready,
  output logic        o_resolved,
  output logic        o_arp_fail,
  output logic [15:0] o_drop_cnt
);

  localparam int unsigned TMR_MAX = (P_ARP_RETRY_CYCLES > P_SEEK_WAIT) ?
                                    P_ARP_RETRY_CYCLES : P_SEEK_WAIT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned TRY_W   = 4;
  localparam int unsigned IP_W    = 32;
  localparam int unsigned MAC_W   = 48;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_ARP_REQ,
    ST_ARP_WAIT,
    ST_PASS,
    ST_DROP
  } state_t;

  state_t             state_q, state_d;
  logic [IP_W-1:0]    dst_ip_q, dst_ip_d;
  logic [IP_W-1:0]    pend_ip_q, pend_ip_d;
  logic               pend_valid_q, pend_valid_d;
  logic               resolved_q, resolved_d;
  logic [TRY_W-1:0]   try_q, try_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [MAC_W-1:0]   dst_mac_q, dst_mac_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               seek_valid_q, seek_valid_d;
  logic               arp_active_q, arp_active_d;
  logic               dst_mac_valid_q, dst_mac_valid_d;
  logic               arp_fail_q, arp_fail_d;
  logic               gate_open_q, gate_open_d;

  logic               in_pass;
  logic               in_drop;
  logic               last_done;
  logic               resolving;

  // Zero-latency pass-through datapath
  assign in_pass           = (state_q == ST_PASS);
  assign in_drop           = (state_q == ST_DROP);
  assign s_axis_user_ready = (in_pass & m_axis_udp_ready) | in_drop;
  assign m_axis_udp_data   = s_axis_user_data;
  assign m_axis_udp_user   = s_axis_user_user;
  assign m_axis_udp_keep   = s_axis_user_keep;
  assign m_axis_udp_last   = s_axis_user_last;
  assign m_axis_udp_valid  = s_axis_user_valid & in_pass;
  assign last_done         = s_axis_user_valid & s_axis_user_ready & s_axis_user_last;
  assign resolving         = (state_q == ST_SEEK) || (state_q == ST_ARP_REQ) ||
                             (state_q == ST_ARP_WAIT);

  assign o_seek_ip           = dst_ip_q;
  assign o_arp_active_dst_ip = dst_ip_q;
  assign o_seek_valid        = seek_valid_q;
  assign o_arp_active        = arp_active_q;
  assign o_dst_mac           = dst_mac_q;
  assign o_dst_mac_valid     = dst_mac_valid_q;
  assign o_resolved          = gate_open_q;
  assign o_arp_fail          = arp_fail_q;
  assign o_drop_cnt          = drop_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      dst_ip_q        <= P_DST_IP_ADDR;
      pend_ip_q       <= '0;
      pend_valid_q    <= 1'b0;
      resolved_q      <= 1'b0;
      try_q           <= '0;
      tmr_q           <= '0;
      dst_mac_q       <= '0;
      drop_cnt_q      <= '0;
      seek_valid_q    <= 1'b0;
      arp_active_q    <= 1'b0;
      dst_mac_valid_q <= 1'b0;
      arp_fail_q      <= 1'b0;
      gate_open_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      dst_ip_q        <= dst_ip_d;
      pend_ip_q       <= pend_ip_d;
      pend_valid_q    <= pend_valid_d;
      resolved_q      <= resolved_d;
      try_q           <= try_d;
      tmr_q           <= tmr_d;
      dst_mac_q       <= dst_mac_d;
      drop_cnt_q      <= drop_cnt_d;
      seek_valid_q    <= seek_valid_d;
      arp_active_q    <= arp_active_d;
      dst_mac_valid_q <= dst_mac_valid_d;
      arp_fail_q      <= arp_fail_d;
      gate_open_q     <= gate_open_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    dst_ip_d        = dst_ip_q;
    pend_ip_d       = pend_ip_q;
    pend_valid_d    = pend_valid_q;
    resolved_d      = resolved_q;
    try_d           = try_q;
    tmr_d           = tmr_q;
    dst_mac_d       = dst_mac_q;
    drop_cnt_d      = drop_cnt_q;
    seek_valid_d    = 1'b0;
    arp_active_d    = 1'b0;
    dst_mac_valid_d = 1'b0;
    arp_fail_d      = 1'b0;

    if (resolving && i_dst_ip_valid) begin
      // New destination while resolving: restart lookup for the new IP
      dst_ip_d     = i_dst_ip;
      resolved_d   = 1'b0;
      try_d        = '0;
      tmr_d        = '0;
      seek_valid_d = 1'b1;
      state_d      = ST_SEEK;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_dst_ip_valid) begin
            dst_ip_d   = i_dst_ip;
            resolved_d = 1'b0;
            try_d      = '0;
          end
          if (s_axis_user_valid) begin
            if (resolved_q && !i_dst_ip_valid) begin
              state_d = ST_PASS;
            end else begin
              state_d      = ST_SEEK;
              tmr_d        = '0;
              seek_valid_d = 1'b1;
            end
          end
        end

        ST_SEEK: begin
          if (i_seek_mac_valid) begin
            dst_mac_d       = i_seek_mac;
            dst_mac_valid_d = 1'b1;
            resolved_d      = 1'b1;
            try_d           = '0;
            state_d         = ST_PASS;
          end else if (tmr_q == TMR_W'(P_SEEK_WAIT - 1)) begin
            if (try_q < TRY_W'(P_ARP_MAX_TRIES)) begin
              arp_active_d = 1'b1;
              state_d      = ST_ARP_REQ;
            end else begin
              arp_fail_d = 1'b1;
              try_d      = '0;
              state_d    = ST_DROP;
            end
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end

        ST_ARP_REQ: begin
          try_d   = try_q + TRY_W'(1);
          tmr_d   = '0;
          state_d = ST_ARP_WAIT;
        end

        // Late cache hits are ignored here; the following lookup catches them
        ST_ARP_WAIT: begin
          if (tmr_q == TMR_W'(P_ARP_RETRY_CYCLES - 1)) begin
            tmr_d        = '0;
            seek_valid_d = 1'b1;
            state_d      = ST_SEEK;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end

        ST_PASS, ST_DROP: begin
          if (i_dst_ip_valid) begin
            pend_ip_d    = i_dst_ip;
            pend_valid_d = 1'b1;
          end
          if (last_done) begin
            state_d = ST_IDLE;
            if (in_drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
              drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
            // Deferred IP change lands on the packet boundary
            if (i_dst_ip_valid || pend_valid_q) begin
              dst_ip_d     = i_dst_ip_valid ? i_dst_ip : pend_ip_q;
              pend_valid_d = 1'b0;
              resolved_d   = 1'b0;
              try_d        = '0;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    gate_open_d = (state_d == ST_PASS);
  end

endmodule

// File: tb/tb_arp_tx_gate_ctrl.sv
// Scoreboard bench for arp_tx_gate_ctrl: directed packets push expected events,
// a negedge monitor pops and compares every DUT strobe and stream beat.
module tb_arp_tx_gate_ctrl;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] user;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  localparam logic [31:0] DEF_IP = 32'hC0A8_6464;
  localparam logic [31:0] NEW_IP = 32'h0A00_0001;

  logic        clk;
  logic        rst;
  logic [31:0] dst_ip;
  logic        dst_ip_valid;
  logic [31:0] seek_ip;
  logic        seek_valid;
  logic [47:0] seek_mac;
  logic        seek_mac_valid;
  logic        arp_active;
  logic [31:0] arp_ip;
  logic [47:0] dst_mac;
  logic        dst_mac_valid;
  logic [63:0] s_data;
  logic [31:0] s_user;
  logic [7:0]  s_keep;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] m_data;
  logic [31:0] m_user;
  logic [7:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic        resolved;
  logic        arp_fail;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit toggle_ready = 0;

  beat_t       exp_beats[$];
  logic [31:0] exp_seek[$];
  logic [47:0] exp_mac[$];
  logic [31:0] exp_arp[$];
  int          arp_times[$];
  int          exp_fail_n = 0;

  arp_tx_gate_ctrl #(
    .P_DST_IP_ADDR      (DEF_IP),
    .P_SEEK_WAIT        (16),
    .P_ARP_RETRY_CYCLES (100),
    .P_ARP_MAX_TRIES    (3)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_dst_ip            (dst_ip),
    .i_dst_ip_valid      (dst_ip_valid),
    .o_seek_ip           (seek_ip),
    .o_seek_valid        (seek_valid),
    .i_seek_mac          (seek_mac),
    .i_seek_mac_valid    (seek_mac_valid),
    .o_arp_active        (arp_active),
    .o_arp_active_dst_ip (arp_ip),
    .o_dst_mac           (dst_mac),
    .o_dst_mac_valid     (dst_mac_valid),
    .s_axis_user_data    (s_data),
    .s_axis_user_user    (s_user),
    .s_axis_user_keep    (s_keep),
    .s_axis_user_last    (s_last),
    .s_axis_user_valid   (s_valid),
    .s_axis_user_ready   (s_ready),
    .m_axis_udp_data     (m_data),
    .m_axis_udp_user     (m_user),
    .m_axis_udp_keep     (m_keep),
    .m_axis_udp_last     (m_last),
    .m_axis_udp_valid    (m_valid),
    .m_axis_udp_ready    (m_ready),
    .o_resolved          (resolved),
    .o_arp_fail          (arp_fail),
    .o_drop_cnt          (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every DUT strobe / accepted beat must match the head of its queue
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (exp_beats.size() == 0) check("unexpected_beat", {63'd0, 1'b1}, 64'd0);
        else begin
          beat_t b;
          b = exp_beats.pop_front();
          check("beat_data", m_data, b.data);
          check("beat_ctl", {23'd0, m_user, m_keep, m_last}, {23'd0, b.user, b.keep, b.last});
        end
      end
      if (seek_valid) begin
        if (exp_seek.size() == 0) check("unexpected_seek", {32'd0, seek_ip}, 64'd0);
        else check("seek_ip", {32'd0, seek_ip}, {32'd0, exp_seek.pop_front()});
      end
      if (dst_mac_valid) begin
        if (exp_mac.size() == 0) check("unexpected_mac", {16'd0, dst_mac}, 64'd0);
        else check("dst_mac", {16'd0, dst_mac}, {16'd0, exp_mac.pop_front()});
      end
      if (arp_active) begin
        arp_times.push_back(cyc);
        if (exp_arp.size() == 0) check("unexpected_arp", {32'd0, arp_ip}, 64'd0);
        else check("arp_ip", {32'd0, arp_ip}, {32'd0, exp_arp.pop_front()});
      end
      if (arp_fail) begin
        if (exp_fail_n == 0) check("unexpected_arp_fail", 64'd1, 64'd0);
        else begin
          exp_fail_n--;
          check("arp_fail_pulse", 64'd1, 64'd1 & {63'd0, arp_fail});
        end
      end
      if (resolved) check("ready_mirror", {63'd0, s_ready}, {63'd0, m_ready});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t mk_beat(input logic [31:0] base, input int i, input bit last);
    beat_t b;
    b.data = {base, 32'(i)};
    b.user = base ^ 32'(i);
    b.keep = (last) ? 8'h0F : 8'hFF;
    b.last = last;
    return b;
  endfunction

  task automatic drive_beat(input beat_t b);
    bit acc;
    int t;
    s_data = b.data; s_user = b.user; s_keep = b.keep; s_last = b.last; s_valid = 1'b1;
    acc = 0;
    t = 0;
    while (!acc && t < 3000) begin
      if (toggle_ready) m_ready = ~m_ready;
      @(negedge clk);
      acc = s_ready;
      tick();
      t++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: got no ready expected accept (cycle %0d)", cyc);
    end
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base, input bit pass);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b = mk_beat(base, i, i == n - 1);
      if (pass) exp_beats.push_back(b);
      drive_beat(b);
    end
    s_valid = 1'b0;
  endtask

  task automatic respond(input int nth, input int dly, input logic [47:0] mac);
    int seen = 0;
    int t = 0;
    while (seen < nth && t < 3000) begin
      @(negedge clk);
      if (seek_valid) seen++;
      t++;
    end
    if (seen < nth) begin
      checks++;
      errors++;
      $display("FAIL seek_wait_timeout: got %0d seeks expected %0d", seen, nth);
    end else begin
      repeat (dly) @(posedge clk);
      #1;
      seek_mac = mac;
      seek_mac_valid = 1'b1;
      tick();
      seek_mac_valid = 1'b0;
    end
  endtask

  task automatic set_ip(input logic [31:0] ip);
    dst_ip = ip;
    dst_ip_valid = 1'b1;
    tick();
    dst_ip_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_strobes"}, {60'd0, seek_valid, arp_active, dst_mac_valid, arp_fail}, 64'd0);
    check({tag, "_gate"}, {61'd0, resolved, s_ready, m_valid}, 64'd0);
    check({tag, "_dst_mac"}, {16'd0, dst_mac}, 64'd0);
    check({tag, "_drop_cnt"}, {48'd0, drop_cnt}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; dst_ip = '0; dst_ip_valid = 1'b0; seek_mac = '0; seek_mac_valid = 1'b0;
    s_data = '0; s_user = '0; s_keep = '0; s_last = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");
    tick();

    // 1: cache hit two cycles after the lookup strobe, 3 beats forwarded
    exp_seek.push_back(DEF_IP);
    exp_mac.push_back(48'h0011_2233_4455);
    fork
      send_pkt(3, 32'h1000_0000, 1);
      respond(1, 2, 48'h0011_2233_4455);
    join
    repeat (3) tick();

    // 2: one miss, ARP request, hit on second lookup
    set_ip(DEF_IP);
    exp_seek.push_back(DEF_IP);
    exp_seek.push_back(DEF_IP);
    exp_arp.push_back(DEF_IP);
    exp_mac.push_back(48'hAABB_CCDD_EEF0);
    fork
      send_pkt(2, 32'h2000_0000, 1);
      respond(2, 3, 48'hAABB_CCDD_EEF0);
    join
    repeat (3) tick();
    check("t2_arp_count", 64'(arp_times.size()), 64'd1);

    // 3: total miss -> 3 ARP requests, fail, packet dropped
    set_ip(DEF_IP);
    arp_times.delete();
    repeat (4) exp_seek.push_back(DEF_IP);
    repeat (3) exp_arp.push_back(DEF_IP);
    exp_fail_n = 1;
    send_pkt(2, 32'h3000_0000, 0);
    @(negedge clk);
    check("t3_drop_cnt", {48'd0, drop_cnt}, 64'd1);
    check("t3_arp_count", 64'(arp_times.size()), 64'd3);
    check("t3_fail_seen", 64'(exp_fail_n), 64'd0);
    if (arp_times.size() == 3) begin
      for (int i = 1; i < 3; i++) begin
        int d;
        d = arp_times[i] - arp_times[i-1];
        check("t3_arp_spacing_ok", {63'd0, (d >= 101 && d <= 120)}, 64'd1);
      end
    end
    tick();

    // 4: resolve, then back-to-back packet straight to PASS with ready toggling
    exp_seek.push_back(DEF_IP);
    exp_mac.push_back(48'h0102_0304_0506);
    fork
      send_pkt(2, 32'h4000_0000, 1);
      respond(1, 1, 48'h0102_0304_0506);
    join
    toggle_ready = 1;
    send_pkt(4, 32'h4100_0000, 1);
    toggle_ready = 0;
    m_ready = 1'b1;
    repeat (3) tick();
    check("t4_no_extra_seek", 64'(exp_seek.size()), 64'd0);

    // 5: IP change mid-packet is deferred to the packet boundary
    fork
      send_pkt(4, 32'h5000_0000, 1);
      begin
        int t = 0;
        while (!resolved && t < 100) begin @(negedge clk); t++; end
        tick();
        set_ip(NEW_IP);
      end
    join
    repeat (2) tick();
    exp_seek.push_back(NEW_IP);
    exp_mac.push_back(48'hCAFE_0000_0001);
    fork
      send_pkt(2, 32'h5100_0000, 1);
      respond(1, 4, 48'hCAFE_0000_0001);
    join
    repeat (3) tick();

    // 6: reset while beat 2 of 4 is presented
    exp_beats.push_back(mk_beat(32'h6000_0000, 0, 0));
    drive_beat(mk_beat(32'h6000_0000, 0, 0));
    begin
      beat_t b1;
      b1 = mk_beat(32'h6000_0000, 1, 0);
      s_data = b1.data; s_user = b1.user; s_keep = b1.keep; s_last = b1.last;
    end
    m_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    check_reset_outputs("t6_reset");
    tick();
    exp_seek.push_back(DEF_IP);
    exp_mac.push_back(48'h7777_8888_9999);
    fork
      send_pkt(2, 32'h6100_0000, 1);
      respond(1, 2, 48'h7777_8888_9999);
    join
    repeat (20) tick();

    check("end_beats_left", 64'(exp_beats.size()), 64'd0);
    check("end_seek_left", 64'(exp_seek.size()), 64'd0);
    check("end_mac_left", 64'(exp_mac.size()), 64'd0);
    check("end_arp_left", 64'(exp_arp.size()), 64'd0);
    check("end_fail_left", 64'(exp_fail_n), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
